// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

   localparam int unsigned RF_DATA_W   = 32;
   localparam int unsigned RF_NUM_REGS = 16;
   localparam int unsigned RF_PC_IDX   = 15;
   localparam int unsigned RF_ADDR_W   = $clog2(RF_NUM_REGS);

   // Number of combinational read ports (two operands plus store data).
   localparam int unsigned NUM_RD = 3;

   typedef logic [RF_ADDR_W-1:0] addr_t;
   typedef logic [RF_DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue and
// cleared by the load writeback port; drives per-read-port busy flags.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = RF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
   parameter int unsigned PC_IDX   = RF_PC_IDX,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           we1,
   input  logic [ADDR_W-1:0]              wa1,
   input  logic                           lock_v,
   input  logic [ADDR_W-1:0]              lock_a,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  ra,
   output logic [NUM_RD-1:0]              busy,
   output logic                           any_busy
);

   localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX);

   logic [NUM_REGS-1:0] pending_q, pending_d;

   // True for addresses backed by real storage (not the PC alias).
   function automatic logic is_reg(input logic [ADDR_W-1:0] a);
      return (a != PcAddr) && (32'(a) < NUM_REGS);
   endfunction

   // Clear on load writeback first, then set on load issue so set wins.
   always_comb begin
      pending_d = pending_q;
      if (we1 && is_reg(wa1)) begin
         pending_d[wa1] = 1'b0;
      end
      if (lock_v && is_reg(lock_a)) begin
         pending_d[lock_a] = 1'b1;
      end
   end

   // Pending vector state, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // A register being written by port 1 this cycle is not busy when its
   // data is forwarded to the reader.
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         busy[k] = 1'b0;
         if (is_reg(ra[k]) && !(BYPASS && we1 && (wa1 == ra[k]))) begin
            busy[k] = pending_q[ra[k]];
         end
      end
   end

   assign any_busy = |pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: three combinational reads, two synchronous
// writes (port 1 wins on collision), PC aliasing, optional write bypass and
// a pending-load scoreboard for the hazard unit.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned   DATA_W   = RF_DATA_W,
   parameter int unsigned   NUM_REGS = RF_NUM_REGS,
   parameter int unsigned   PC_IDX   = RF_PC_IDX,
   parameter bit            BYPASS   = 1'b1,
   localparam int unsigned  ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd1,
   input  logic [ADDR_W-1:0] ra0,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [DATA_W-1:0] pc_val,
   output logic [DATA_W-1:0] rd0,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              lock_v,
   input  logic [ADDR_W-1:0] lock_a,
   output logic              busy0,
   output logic              busy1,
   output logic              busy2,
   output logic              any_busy
);

   localparam int unsigned       NUM_SLOTS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PcAddr    = ADDR_W'(PC_IDX);

   logic [DATA_W-1:0]             mem [NUM_SLOTS];
   logic [NUM_RD-1:0][ADDR_W-1:0] ra;
   logic [DATA_W-1:0]             rd  [NUM_RD];
   logic [NUM_RD-1:0]             busy;
   logic                          wr0_ok, wr1_ok;

   assign ra = {ra2, ra1, ra0};

   // Writes (and their bypass) only target real storage while out of reset.
   assign wr0_ok = we0 && rst_n && (wa0 != PcAddr) && (32'(wa0) < NUM_REGS);
   assign wr1_ok = we1 && rst_n && (wa1 != PcAddr) && (32'(wa1) < NUM_REGS);

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_reg
      if ((i == PC_IDX) || (i >= NUM_REGS)) begin : g_none
         assign mem[i] = '0;
      end else begin : g_store
         logic [DATA_W-1:0] q;
         // One storage word; port 1 has priority over port 0.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q <= '0;
            end else if (wr1_ok && (wa1 == ADDR_W'(i))) begin
               q <= wd1;
            end else if (wr0_ok && (wa0 == ADDR_W'(i))) begin
               q <= wd0;
            end
         end
         assign mem[i] = q;
      end
   end

   // Read muxing: PC alias, then port 1 bypass, then port 0 bypass, then storage.
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rd[k] = mem[ra[k]];
         if (ra[k] == PcAddr) begin
            rd[k] = pc_val;
         end else if (BYPASS && wr1_ok && (wa1 == ra[k])) begin
            rd[k] = wd1;
         end else if (BYPASS && wr0_ok && (wa0 == ra[k])) begin
            rd[k] = wd0;
         end
      end
   end

   assign rd0 = rd[0];
   assign rd1 = rd[1];
   assign rd2 = rd[2];

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .PC_IDX   (PC_IDX),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .we1      (we1),
      .wa1      (wa1),
      .lock_v   (lock_v),
      .lock_a   (lock_a),
      .ra       (ra),
      .busy     (busy),
      .any_busy (any_busy)
   );

   assign busy0 = busy[0];
   assign busy1 = busy[1];
   assign busy2 = busy[2];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one bypassing and one non-bypassing instance share
// stimulus and are compared against an array-based model of the register file.
module tb_regfile_mp;
   import regfile_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  we0 = 1'b0, we1 = 1'b0, lock_v = 1'b0;
   addr_t wa0 = '0, wa1 = '0, ra0 = '0, ra1 = '0, ra2 = '0, lock_a = '0;
   word_t wd0 = '0, wd1 = '0, pc_val = '0;

   word_t rd0_b, rd1_b, rd2_b, rd0_n, rd1_n, rd2_n;
   logic  busy0_b, busy1_b, busy2_b, any_busy_b;
   logic  busy0_n, busy1_n, busy2_n, any_busy_n;

   int n_vec = 0;
   int n_err = 0;

   word_t m_regs [16];
   bit    m_pend [16];

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra0(ra0), .ra1(ra1), .ra2(ra2), .pc_val(pc_val),
      .rd0(rd0_b), .rd1(rd1_b), .rd2(rd2_b),
      .lock_v(lock_v), .lock_a(lock_a),
      .busy0(busy0_b), .busy1(busy1_b), .busy2(busy2_b), .any_busy(any_busy_b)
   );

   regfile_mp #(.BYPASS(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra0(ra0), .ra1(ra1), .ra2(ra2), .pc_val(pc_val),
      .rd0(rd0_n), .rd1(rd1_n), .rd2(rd2_n),
      .lock_v(lock_v), .lock_a(lock_a),
      .busy0(busy0_n), .busy1(busy1_n), .busy2(busy2_n), .any_busy(any_busy_n)
   );

   // Expected read value from the architectural rules.
   function automatic word_t exp_rd(input addr_t a, input bit byp);
      if (a == 4'd15) return pc_val;
      if (byp && we1 && wa1 == a) return wd1;
      if (byp && we0 && wa0 == a) return wd0;
      return m_regs[a];
   endfunction

   function automatic bit exp_busy(input addr_t a, input bit byp);
      if (a == 4'd15) return 1'b0;
      if (byp && we1 && wa1 == a) return 1'b0;
      return m_pend[a];
   endfunction

   function automatic bit exp_any();
      bit r = 1'b0;
      for (int i = 0; i < 16; i++) r |= m_pend[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic idle();
      we0 = 1'b0;
      we1 = 1'b0;
      lock_v = 1'b0;
   endtask

   // Advance one clock; the model commits this cycle's inputs at the edge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         if (we0 && wa0 != 4'd15) m_regs[wa0] = wd0;
         if (we1 && wa1 != 4'd15) begin
            m_regs[wa1] = wd1;
            m_pend[wa1] = 1'b0;
         end
         if (lock_v && lock_a != 4'd15) m_pend[lock_a] = 1'b1;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Still in power-on reset.
      ra0 = 4'd3; ra1 = 4'd15; pc_val = 32'h108;
      #1;
      n_vec++; if (rd0_b !== 32'h0) begin n_err++; $display("FAIL por_rd0: got %h want 0", rd0_b); end
      n_vec++; if (rd1_b !== 32'h108) begin n_err++; $display("FAIL por_rd1_pc: got %h want 108", rd1_b); end
      n_vec++; if (any_busy_b !== 1'b0) begin n_err++; $display("FAIL por_any_busy: got %b want 0", any_busy_b); end
      rst_n = 1'b1;
      model_reset();
      tick();
      // Load r3 and mark r4 pending, then reset mid-cycle.
      we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEADBEEF; lock_v = 1'b1; lock_a = 4'd4;
      tick();
      idle(); ra2 = 4'd4;
      #1;
      n_vec++; if (rd0_n !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_rst_rd0: got %h want deadbeef", rd0_n); end
      n_vec++; if (busy2_b !== 1'b1) begin n_err++; $display("FAIL pre_rst_busy2: got %b want 1", busy2_b); end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++; if (rd0_b !== 32'h0) begin n_err++; $display("FAIL rst_rd0_b: got %h want 0", rd0_b); end
      n_vec++; if (rd0_n !== 32'h0) begin n_err++; $display("FAIL rst_rd0_n: got %h want 0", rd0_n); end
      n_vec++; if (rd1_b !== 32'h108) begin n_err++; $display("FAIL rst_rd1_pc: got %h want 108", rd1_b); end
      n_vec++; if (busy2_b !== 1'b0 || any_busy_b !== 1'b0) begin
         n_err++; $display("FAIL rst_busy: got %b/%b want 0/0", busy2_b, any_busy_b); end
      // A write presented during reset is not forwarded.
      we0 = 1'b1; wa0 = 4'd3; wd0 = 32'h55;
      #1;
      n_vec++; if (rd0_b !== 32'h0) begin n_err++; $display("FAIL rst_no_bypass: got %h want 0", rd0_b); end
      we0 = 1'b0;
      rst_n = 1'b1;
      tick();
      // Previously pending register still writes normally via port 1.
      we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h99;
      tick();
      idle();
      #1;
      n_vec++; if (rd2_n !== 32'h99 || busy2_n !== 1'b0) begin
         n_err++; $display("FAIL post_rst_we1: got %h/%b want 99/0", rd2_n, busy2_n); end
   endtask

   task automatic test_bypass();
      word_t old;
      old = m_regs[5];
      ra0 = 4'd5; we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11;
      #1;
      n_vec++; if (rd0_b !== 32'h11) begin n_err++; $display("FAIL bypass_same_cycle: got %h want 11", rd0_b); end
      n_vec++; if (rd0_n !== old) begin n_err++; $display("FAIL nobypass_old: got %h want %h", rd0_n, old); end
      tick();
      idle();
      #1;
      n_vec++; if (rd0_n !== 32'h11 || rd0_b !== 32'h11) begin
         n_err++; $display("FAIL write_visible: got %h/%h want 11/11", rd0_n, rd0_b); end
   endtask

   task automatic test_collision();
      ra0 = 4'd7;
      we0 = 1'b1; wa0 = 4'd7; wd0 = 32'hAAAA;
      we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h5555;
      #1;
      n_vec++; if (rd0_b !== 32'h5555) begin n_err++; $display("FAIL collide_bypass: got %h want 5555", rd0_b); end
      tick();
      idle();
      #1;
      n_vec++; if (rd0_n !== 32'h5555) begin n_err++; $display("FAIL collide_store: got %h want 5555", rd0_n); end
   endtask

   task automatic test_scoreboard();
      ra0 = 4'd4; lock_v = 1'b1; lock_a = 4'd4;
      tick();
      idle();
      n_vec++; if (busy0_b !== 1'b1 || busy0_n !== 1'b1) begin
         n_err++; $display("FAIL lock_busy: got %b/%b want 1/1", busy0_b, busy0_n); end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_vec++; if (busy0_b !== 1'b1 || any_busy_b !== 1'b1) begin
            n_err++; $display("FAIL lock_hold%0d: got %b/%b want 1/1", c, busy0_b, any_busy_b); end
      end
      we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h77;
      #1;
      n_vec++; if (busy0_b !== 1'b0 || rd0_b !== 32'h77) begin
         n_err++; $display("FAIL load_fwd: got %b/%h want 0/77", busy0_b, rd0_b); end
      n_vec++; if (busy0_n !== 1'b1) begin n_err++; $display("FAIL load_nofwd_busy: got %b want 1", busy0_n); end
      tick();
      idle();
      #1;
      n_vec++; if (busy0_n !== 1'b0 || rd0_n !== 32'h77 || any_busy_n !== 1'b0) begin
         n_err++; $display("FAIL load_done: got %b/%h/%b want 0/77/0", busy0_n, rd0_n, any_busy_n); end
   endtask

   task automatic test_lock_clear();
      ra0 = 4'd2; lock_v = 1'b1; lock_a = 4'd2;
      tick();
      we1 = 1'b1; wa1 = 4'd2; wd1 = 32'h22;
      tick();
      idle();
      #1;
      n_vec++; if (busy0_b !== 1'b1 || busy0_n !== 1'b1 || any_busy_b !== 1'b1) begin
         n_err++; $display("FAIL set_wins: got %b/%b/%b want 1/1/1", busy0_b, busy0_n, any_busy_b); end
      we1 = 1'b1; wa1 = 4'd2; wd1 = 32'h23;
      tick();
      idle();
      lock_v = 1'b1; lock_a = 4'd15;
      tick();
      idle(); ra0 = 4'd15;
      #1;
      n_vec++; if (any_busy_b !== 1'b0 || busy0_b !== 1'b0) begin
         n_err++; $display("FAIL pc_lock: got %b/%b want 0/0", any_busy_b, busy0_b); end
   endtask

   task automatic test_pc_write();
      ra0 = 4'd15; pc_val = 32'hCAFE;
      we0 = 1'b1; wa0 = 4'd15; wd0 = 32'h1234;
      we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h4321;
      #1;
      n_vec++; if (rd0_b !== 32'hCAFE) begin n_err++; $display("FAIL pc_passthru: got %h want cafe", rd0_b); end
      tick();
      idle();
      for (int a = 0; a < 15; a++) begin
         ra0 = addr_t'(a);
         #1;
         n_vec++; if (rd0_n !== m_regs[a] || rd0_b !== m_regs[a]) begin
            n_err++; $display("FAIL dump_r%0d: got %h/%h want %h", a, rd0_n, rd0_b, m_regs[a]); end
         tick();
      end
      n_vec++; if (any_busy_n !== exp_any()) begin
         n_err++; $display("FAIL pc_write_sb: got %b want %b", any_busy_n, exp_any()); end
   endtask

   task automatic test_random();
      addr_t ras [3];
      word_t gb [3], gn [3];
      logic  bb [3], bn [3];
      for (int it = 0; it < 300; it++) begin
         we0 = 1'($urandom_range(1)); wa0 = addr_t'($urandom_range(15)); wd0 = $urandom;
         we1 = 1'($urandom_range(1)); wa1 = addr_t'($urandom_range(15)); wd1 = $urandom;
         lock_v = ($urandom_range(3) == 0); lock_a = addr_t'($urandom_range(15));
         ra0 = addr_t'($urandom_range(15)); ra1 = addr_t'($urandom_range(15));
         ra2 = addr_t'($urandom_range(15)); pc_val = $urandom;
         #1;
         ras = '{ra0, ra1, ra2};
         gb = '{rd0_b, rd1_b, rd2_b};
         gn = '{rd0_n, rd1_n, rd2_n};
         bb = '{busy0_b, busy1_b, busy2_b};
         bn = '{busy0_n, busy1_n, busy2_n};
         for (int k = 0; k < 3; k++) begin
            n_vec++; if (gb[k] !== exp_rd(ras[k], 1'b1)) begin
               n_err++; $display("FAIL rand%0d_rd%0d_b: got %h want %h", it, k, gb[k], exp_rd(ras[k], 1'b1)); end
            n_vec++; if (gn[k] !== exp_rd(ras[k], 1'b0)) begin
               n_err++; $display("FAIL rand%0d_rd%0d_n: got %h want %h", it, k, gn[k], exp_rd(ras[k], 1'b0)); end
            n_vec++; if (bb[k] !== exp_busy(ras[k], 1'b1)) begin
               n_err++; $display("FAIL rand%0d_busy%0d_b: got %b want %b", it, k, bb[k], exp_busy(ras[k], 1'b1)); end
            n_vec++; if (bn[k] !== exp_busy(ras[k], 1'b0)) begin
               n_err++; $display("FAIL rand%0d_busy%0d_n: got %b want %b", it, k, bn[k], exp_busy(ras[k], 1'b0)); end
         end
         n_vec++; if (any_busy_b !== exp_any() || any_busy_n !== exp_any()) begin
            n_err++; $display("FAIL rand%0d_any: got %b/%b want %b", it, any_busy_b, any_busy_n, exp_any()); end
         tick();
      end
      idle();
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      #1;
      test_reset();
      test_bypass();
      test_collision();
      test_scoreboard();
      test_lock_clear();
      test_pc_write();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
